// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU-control codes, ALUOp encodings, funct codes and MDU FSM states
package alu_ctrl_pkg;
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_NAND  = 4'd2;
    localparam logic [3:0] ALU_NOR   = 4'd3;
    localparam logic [3:0] ALU_ADDU  = 4'd4;
    localparam logic [3:0] ALU_SUBU  = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_EQUAL = 4'd7;
    localparam logic [3:0] ALU_SFT   = 4'd8;
    localparam logic [3:0] ALU_SFTV  = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [2:0] OP_R_TYPE = 3'd0;
    localparam logic [2:0] OP_ADDI   = 3'd1;
    localparam logic [2:0] OP_SLTIU  = 3'd2;
    localparam logic [2:0] OP_BEQ    = 3'd3;
    localparam logic [2:0] OP_LUI    = 3'd4;
    localparam logic [2:0] OP_ORI    = 3'd5;
    localparam logic [2:0] OP_BNE    = 3'd6;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SFT     = 6'b000011;
    localparam logic [5:0] F_SFTV    = 6'b000111;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MTHI    = 6'b010001;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MTLO    = 6'b010011;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath, one shift-add or restoring step per enabled cycle
//   start_i latches magnitudes and sign flags; step_i advances one bit;
//   hi_o/lo_o give the fixed-up result the current step would produce; last_o flags an exhausted multiplier
module mdu_iter import alu_ctrl_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);
    // mul: acc=product, x=shifting multiplicand, y=shifting multiplier
    // div: acc={remainder, dividend/quotient}, x[WIDTH-1:0]=divisor
    logic [2*WIDTH-1:0] acc, x, acc_nx, prod;
    logic [WIDTH-1:0]   y, ua, ub, rem_nx, quo_nx;
    logic [WIDTH:0]     sh;
    logic               div_r, nq, nr, dz, ge;
    assign ua     = (sgn_i & a_i[WIDTH-1]) ? -a_i : a_i;
    assign ub     = (sgn_i & b_i[WIDTH-1]) ? -b_i : b_i;
    assign sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge     = sh >= {1'b0, x[WIDTH-1:0]};
    assign rem_nx = ge ? WIDTH'(sh - {1'b0, x[WIDTH-1:0]}) : sh[WIDTH-1:0];
    assign quo_nx = {acc[WIDTH-2:0], ge};
    assign acc_nx = div_r ? {rem_nx, quo_nx} : acc + (y[0] ? x : '0);
    assign prod   = nq ? -acc_nx : acc_nx;
    // a zero divisor leaves the untouched dividend magnitude in the remainder, so the
    // dividend-sign fix-up restores the original dividend in HI
    assign hi_o   = div_r ? (nr ? -rem_nx : rem_nx) : prod[2*WIDTH-1:WIDTH];
    assign lo_o   = div_r ? (dz ? '1 : (nq ? -quo_nx : quo_nx)) : prod[WIDTH-1:0];
    assign last_o = ~div_r & (y[WIDTH-1:1] == '0);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {acc, x, y, div_r, nq, nr, dz} <= '0;
        end else if (start_i) begin
            acc   <= div_i ? {{WIDTH{1'b0}}, ua} : '0;
            x     <= {{WIDTH{1'b0}}, div_i ? ub : ua};
            y     <= ub;
            div_r <= div_i;
            nq    <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            nr    <= sgn_i & a_i[WIDTH-1];
            dz    <= b_i == '0;
        end else if (step_i) begin
            acc <= acc_nx;
            x   <= div_r ? x : x << 1;
            y   <= y >> 1;
        end
    end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU-control/sign-extend decode plus iterative MULT/DIV unit with HI/LO and stall
//   decode: ALUOp_i/funct_i -> ALUCtrl_o, Sign_extend_o (combinational)
//   mdu: valid_i, src1_i, src2_i -> stall_o, done_o, hi_o, lo_o, hilo_rd_o, mdu_data_o
//   clk_i rising edge, rst_i asynchronous active-low
//   MDU_EARLY_TERM_EN: when defined, multiplies finish once the remaining multiplier is zero
module alu_ctrl_mdu import alu_ctrl_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [5:0]       funct_i,
    input  logic [2:0]       ALUOp_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             Sign_extend_o,
    output logic             stall_o,
    output logic             hilo_rd_o,
    output logic [WIDTH-1:0] mdu_data_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done_o
);
`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             done_q, is_r, mul_op, div_op, mfhi, mflo, mthi, mtlo, busy, start, finish, last;
    always_comb begin
        ALUCtrl_o     = ALU_ADDU;
        Sign_extend_o = (ALUOp_i == OP_ADDI) | (ALUOp_i == OP_SLTIU) | (ALUOp_i == OP_BEQ) | (ALUOp_i == OP_BNE);
        case (ALUOp_i)
            OP_R_TYPE:
                case (funct_i)
                    F_SUBU:  ALUCtrl_o = ALU_SUBU;
                    F_AND:   ALUCtrl_o = ALU_AND;
                    F_OR:    ALUCtrl_o = ALU_OR;
                    F_SLT:   ALUCtrl_o = ALU_SLT;
                    F_SFT:   ALUCtrl_o = ALU_SFT;
                    F_SFTV:  ALUCtrl_o = ALU_SFTV;
                    default: ALUCtrl_o = ALU_ADDU;
                endcase
            OP_SLTIU:       ALUCtrl_o = ALU_SLT;
            OP_BEQ, OP_BNE: ALUCtrl_o = ALU_EQUAL;
            OP_LUI:         ALUCtrl_o = ALU_LUI;
            OP_ORI:         ALUCtrl_o = ALU_OR;
            default:        ALUCtrl_o = ALU_ADDU;
        endcase
    end
    assign is_r   = valid_i & (ALUOp_i == OP_R_TYPE);
    assign mul_op = is_r & ((funct_i == F_MULT) | (funct_i == F_MULTU));
    assign div_op = is_r & ((funct_i == F_DIV) | (funct_i == F_DIVU));
    assign mfhi   = is_r & (funct_i == F_MFHI);
    assign mflo   = is_r & (funct_i == F_MFLO);
    assign mthi   = is_r & (funct_i == F_MTHI);
    assign mtlo   = is_r & (funct_i == F_MTLO);
    assign busy   = state != S_IDLE;
    // done_q keeps the just-finished instruction, still in execute, from starting again
    assign start  = rst_i & (mul_op | div_op) & ~busy & ~done_q;
    assign finish = busy & ((cnt == CNT_W'(1)) | (EARLY & (state == S_MUL) & last));
    // MF*/MT* during a busy cycle are already covered by busy
    assign stall_o    = rst_i & (start | busy);
    assign hilo_rd_o  = rst_i & ~busy & (mfhi | mflo);
    assign mdu_data_o = hilo_rd_o ? (mfhi ? hi_o : lo_o) : '0;
    assign done_o     = done_q;
    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start),
        .step_i  (busy),
        .div_i   (div_op),
        .sgn_i   (~funct_i[0]),
        .a_i     (src1_i),
        .b_i     (src2_i),
        .hi_o    (r_hi),
        .lo_o    (r_lo),
        .last_o  (last)
    );
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            hi_o   <= '0;
            lo_o   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (start) begin
                state <= mul_op ? S_MUL : S_DIV;
                cnt   <= CNT_W'(WIDTH);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                if (finish) begin
                    state <= S_IDLE;
                    hi_o  <= r_hi;
                    lo_o  <= r_lo;
                end
            end else begin
                if (mthi) hi_o <= src1_i;
                if (mtlo) lo_o <= src1_i;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed plus randomized self-checking bench for alu_ctrl_mdu against an arithmetic model
module tb_alu_ctrl_mdu;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] ADDU = 6'b100001;
    logic         clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0;
    logic [5:0]   funct_i = ADDU;
    logic [2:0]   ALUOp_i = 3'd0;
    logic [W-1:0] src1_i = '0, src2_i = '0;
    logic [3:0]   ALUCtrl_o;
    logic         Sign_extend_o, stall_o, hilo_rd_o, done_o;
    logic [W-1:0] mdu_data_o, hi_o, lo_o;
    int errors = 0, checks = 0;
    alu_ctrl_mdu #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
        .src1_i(src1_i), .src2_i(src2_i), .ALUCtrl_o(ALUCtrl_o), .Sign_extend_o(Sign_extend_o),
        .stall_o(stall_o), .hilo_rd_o(hilo_rd_o), .mdu_data_o(mdu_data_o), .hi_o(hi_o), .lo_o(lo_o),
        .done_o(done_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        if (f == MULT) p = sa * sb;
        else if (f == MULTU) p = ua * ub;
        else if (b == 0) p = {a, 32'hFFFFFFFF};
        else if (f == DIV) p = {32'(sa % sb), 32'(sa / sb)};
        else p = {32'(ua % ub), 32'(ua / ub)};
        eh = p[63:32];
        el = p[31:0];
    endtask
    function automatic int exp_stall(input logic [5:0] f, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
        if (f == MULT || f == MULTU) begin
            logic [31:0] m;
            int n;
            m = (f == MULT && b[31]) ? -b : b;
            n = 0;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return 1 + (n < 1 ? 1 : n);
        end
`endif
        return W + 1;
    endfunction
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n;
        ref_op(f, a, b, eh, el);
        valid_i = 1'b1; ALUOp_i = 3'd0; funct_i = f; src1_i = a; src2_i = b;
        #1;
        n = 0;
        while (stall_o && n < 200) begin
            n++;
            @(posedge clk_i); #1;
        end
        check({tag, " stall"}, 64'(n), 64'(exp_stall(f, b)));
        check({tag, " done"}, 64'(done_o), 64'd1);
        check({tag, " hi"}, 64'(hi_o), 64'(eh));
        check({tag, " lo"}, 64'(lo_o), 64'(el));
        valid_i = 1'b0; funct_i = ADDU;
        @(posedge clk_i); #1;
        check({tag, " done clr"}, 64'(done_o), 64'd0);
    endtask
    logic [2:0]  dec_op  [15] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [5:0]  dec_fn  [15] = '{6'b101010, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b000011, 6'b000111, 6'b111111,
                                  MULT, MULT, DIV, MULTU, DIVU, MULT, MULT};
    logic [3:0]  dec_ctl [15] = '{4'd6, 4'd4, 4'd5, 4'd0, 4'd1, 4'd8, 4'd9, 4'd4, 4'd4, 4'd6, 4'd7, 4'd10, 4'd1, 4'd7, 4'd4};
    logic        dec_se  [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    initial begin
        logic [31:0] eh, el, a, b;
        logic [5:0] f;
        int n;
        #2 rst_i = 1'b0;
        valid_i = 1'b1; funct_i = MULT; src1_i = 32'd9; src2_i = 32'd9;
        #1;
        check("rst stall", 64'(stall_o), 64'd0);
        check("rst done", 64'(done_o), 64'd0);
        check("rst hi", 64'(hi_o), 64'd0);
        check("rst lo", 64'(lo_o), 64'd0);
        funct_i = MFHI;
        #1;
        check("rst hilo_rd", 64'(hilo_rd_o), 64'd0);
        check("rst mdu_data", 64'(mdu_data_o), 64'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0; funct_i = ADDU;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ALUOp_i = dec_op[i]; funct_i = dec_fn[i];
            #1;
            check($sformatf("dec%0d ctrl", i), 64'(ALUCtrl_o), 64'(dec_ctl[i]));
            check($sformatf("dec%0d sext", i), 64'(Sign_extend_o), 64'(dec_se[i]));
            check($sformatf("dec%0d stall", i), 64'(stall_o), 64'd0);
        end
        check("dec7 no X", 64'($isunknown({ALUCtrl_o, Sign_extend_o, stall_o, hilo_rd_o, mdu_data_o, hi_o, lo_o, done_o})), 64'd0);
        ALUOp_i = 3'd0; valid_i = 1'b0; funct_i = ADDU;
        @(posedge clk_i); #1;
        valid_i = 1'b1; funct_i = MTLO; src1_i = 32'h1234;
        #1 check("mtlo stall", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        funct_i = MFLO; src1_i = 32'h0;
        #1;
        check("mflo rd", 64'(hilo_rd_o), 64'd1);
        check("mflo data", 64'(mdu_data_o), 64'h1234);
        check("mflo stall", 64'(stall_o), 64'd0);
        funct_i = MTHI; src1_i = 32'hCAFE0001;
        @(posedge clk_i); #1;
        funct_i = MFHI;
        #1;
        check("mfhi data", 64'(mdu_data_o), 64'hCAFE0001);
        check("mfhi lo kept", 64'(lo_o), 64'h1234);
        valid_i = 1'b0; funct_i = ADDU;
        @(posedge clk_i); #1;
        run_op("mult -3*7", MULT, 32'hFFFFFFFD, 32'd7);
        run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu 7/0", DIVU, 32'd7, 32'd0);
        run_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0);
        run_op("multu 7f*3", MULTU, 32'h7F, 32'd3);
        run_op("mult min*-1", MULT, 32'h80000000, 32'hFFFFFFFF);
        ref_op(MULT, 32'h12345678, 32'h100, eh, el);
        valid_i = 1'b1; funct_i = MULT; src1_i = 32'h12345678; src2_i = 32'h100;
        #1 check("mfhi-after-mult accept", 64'(stall_o), 64'd1);
        @(posedge clk_i); #1;
        funct_i = MFHI; src1_i = '0; src2_i = '0;
        n = 1;
        while (stall_o && n < 200) begin
            n++;
            @(posedge clk_i); #1;
        end
        check("mfhi-after-mult stall", 64'(n), 64'(exp_stall(MULT, 32'h100)));
        check("mfhi-after-mult rd", 64'(hilo_rd_o), 64'd1);
        check("mfhi-after-mult data", 64'(mdu_data_o), 64'(eh));
        valid_i = 1'b0; funct_i = ADDU;
        @(posedge clk_i); #1;
        valid_i = 1'b1; funct_i = DIVU; src1_i = 32'd100; src2_i = 32'd3;
        @(posedge clk_i); #1;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk_i); #1;
        end
        check("divu busy10 stall", 64'(stall_o), 64'd1);
        rst_i = 1'b0;
        #1;
        check("midrst stall", 64'(stall_o), 64'd0);
        check("midrst hi", 64'(hi_o), 64'd0);
        check("midrst lo", 64'(lo_o), 64'd0);
        check("midrst done", 64'(done_o), 64'd0);
        valid_i = 1'b0; funct_i = ADDU;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        run_op("multu 5*5", MULTU, 32'd5, 32'd5);
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (i[0]) a = a >> $urandom_range(0, 31);
            if (f == DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            run_op($sformatf("rnd%0d f=%b", i, f), f, a, b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder.
- Keeps the combinational funct/ALUOp → ALU-control and sign-extend decode, with every output driven in every branch.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers, MFHI/MFLO/MTHI/MTLO, and a stall output that freezes PC/pipeline while an op runs.
- Sits beside the ALU in the execute path of the CPU.

Parameters:
WIDTH, 32, operand/HI/LO width (≥4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
valid_i  in  1  instruction in execute stage is valid
funct_i  in  6  instruction funct field
ALUOp_i  in  3  ALUOp from decoder (R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6)
src1_i  in  WIDTH  rs value (dividend / multiplicand)
src2_i  in  WIDTH  rt value (divisor / multiplier)
ALUCtrl_o  out  4  ALU operation (AND=0 OR=1 NAND=2 NOR=3 ADDU=4 SUBU=5 SLT=6 EQUAL=7 SFT=8 SFTV=9 LUI=10)
Sign_extend_o  out  1  immediate sign-extend select
stall_o  out  1  hold PC and pipeline registers
hilo_rd_o  out  1  writeback takes mdu_data_o instead of ALU result (MFHI/MFLO)
mdu_data_o  out  WIDTH  HI for MFHI, LO for MFLO, else 0
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register
done_o  out  1  one-cycle pulse after an MDU op completes

Behaviour:
- Decode (combinational), R_TYPE: 100001→ADDU, 100011→SUBU, 100100→AND, 100101→OR, 101010→SLT, 000011→SFT, 000111→SFTV; any other funct→ADDU.
- Decode, other ALUOps: ADDI→ADDU, SLTIU→SLT, BEQ→EQUAL, BNE→EQUAL, LUI→LUI, ORI→OR. Undefined ALUOp→ADDU, Sign_extend_o=0.
- Sign_extend_o=1 for ADDI, SLTIU, BEQ, BNE; 0 otherwise.
- MDU funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. They are recognised only when ALUOp_i==R_TYPE and valid_i=1.
- start = MDU op & state==IDLE & ~done_q.
- stall_o = start | (state!=IDLE) | (MFHI/MFLO/MTHI/MTLO while state!=IDLE).
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL/DIV on start. On that edge, latch |src1|,|src2| (signed ops) or raw values (unsigned), latch the result-sign flags, and set cnt=WIDTH.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - cnt decrements each cycle. On the edge where cnt==1, write HI/LO (signed fix-up applied), go to IDLE, set done_q.
- Latency: stall_o is high for exactly WIDTH+1 cycles (accept cycle + WIDTH busy cycles). In the next cycle done_o=1 and stall_o=0; done_q suppresses re-start of the still-present instruction; done_q clears one cycle later.
- MULT/MULTU results: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
- DIV/DIVU results: LO = quotient, HI = remainder. Signed: quotient sign = sign(a)^sign(b); remainder sign = sign(dividend).
- Divide by zero: completes with normal latency; LO = all ones, HI = original dividend.
- MTHI/MTLO (IDLE): HI/LO ← src1_i on the clock edge, no stall.
- MFHI/MFLO (IDLE): hilo_rd_o=1, mdu_data_o combinational from HI/LO.
- During MUL/DIV, a new MDU op has no effect beyond stall; ALU-only instructions cannot occur because the pipeline is held.
- Reset (any time, including mid-operation): state=IDLE, HI=LO=0, cnt=0, done_q=0. Outputs: stall_o=0, done_o=0, hilo_rd_o=0, mdu_data_o=0. Decode outputs follow inputs.

Optional Feature:
MDU_EARLY_TERM_EN
- Defined: MUL finishes on the edge where the remaining (shifted) multiplier is zero. Stall = 1 + max(1, index of highest set bit of |multiplier| + 1) cycles; a zero multiplier stalls 2 cycles. DIV is unchanged.
- Undefined: fixed WIDTH+1 stall cycles for all ops.

Decomposition:
- Package alu_ctrl_pkg holds: ALU-control localparams, ALUOp encodings, MDU funct codes, and the FSM state enum.
- One sub-module, mdu_iter: datapath only (partial remainder/product registers, one step per enable, sign fix-up). It takes start/op/operands and returns hi/lo/last.
- FSM, stall logic and decode stay in alu_ctrl_mdu.

Test Plan:
- Decode sweep: R_TYPE funct 101010 → ALUCtrl_o=6, Sign_extend_o=0; ALUOp BNE → ALUCtrl_o=7, Sign_extend_o=1; ALUOp=7 → ALUCtrl_o=4, Sign_extend_o=0, no X on any output.
- MULT, WIDTH=32: src1=-3, src2=7 → stall_o high 33 cycles, then done_o; HI=FFFFFFFF, LO=FFFFFFEB.
- DIV: -7/2 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU: 7/0 → LO=FFFFFFFF, HI=00000007.
- MTLO 0x1234 then MFLO in the next cycle → hilo_rd_o=1, mdu_data_o=0x1234, stall_o=0. MFHI issued in the cycle after MULT → stall held until done, then HI returned.
- Drop rst_i low at busy cycle 10 of DIVU → immediate IDLE, stall_o=0, HI=LO=0. After release, MULTU 5×5 → LO=25, HI=0.
- WIDTH=8, MDU_EARLY_TERM_EN defined: MULTU 0x7F×0x03 → stall 3 cycles, LO=0x7D, HI=0x01. Same without macro → 9 cycles, same result.
